// File: rtl/uart_baud_timer_pkg.sv
`default_nettype none
// ============================================================================
// uart_timer_pkg : shared state enum, mode constants and parameter defaults
// Rev 1.0
// ============================================================================
package uart_timer_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } timer_state_t;

  localparam logic MODE_PERIODIC = 1'b0;
  localparam logic MODE_ONESHOT  = 1'b1;

  localparam int DEF_DIV_W = 24;
  localparam int DEF_OVS   = 16;
  localparam int DEF_CNT_W = 8;

endpackage
`default_nettype wire

// File: rtl/uart_baud_timer_if.sv
`default_nettype none
// ============================================================================
// uart_baud_timer_if : control inputs and tick outputs of the baud timer
// Rev 1.0
// ============================================================================
interface uart_baud_timer_if
  import uart_timer_pkg::*;
#(
  parameter int DIV_W = DEF_DIV_W,
  parameter int CNT_W = DEF_CNT_W
);

  logic             enable;
  logic [DIV_W-1:0] divisor;
  logic             mode;
  logic             start;
  logic [CNT_W-1:0] bits;
  logic             ovs_tick;
  logic             bit_tick;
  logic             half_tick;
  logic             busy;
  logic             done;

  modport master (
    output enable, divisor, mode, start, bits,
    input  ovs_tick, bit_tick, half_tick, busy, done
  );

  modport slave (
    input  enable, divisor, mode, start, bits,
    output ovs_tick, bit_tick, half_tick, busy, done
  );

endinterface
`default_nettype wire

// File: rtl/uart_baud_timer_prescaler.sv
`default_nettype none
// ============================================================================
// tick_prescaler : one-cycle tick every `divisor` clocks while clear is low
// Rev 1.0
// ============================================================================
module tick_prescaler
  import uart_timer_pkg::*;
#(
  parameter int DIV_W = DEF_DIV_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic [DIV_W-1:0] divisor,
  output logic             tick
);

  logic [DIV_W-1:0] count;

  // Count starts at 0 on the first enabled cycle, so the tick lands on cycle D.
  assign tick = !clear && (count == divisor - DIV_W'(1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear || tick) begin
      count <= '0;
    end else begin
      count <= count + DIV_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_baud_timer.sv
`default_nettype none
// ============================================================================
// uart_baud_timer : periodic / one-shot oversample and bit-period tick timer
// Optional mid-bit tick enabled by macro UART_BAUD_TIMER_HALF_EN. Rev 1.0
// ============================================================================
module uart_baud_timer
  import uart_timer_pkg::*;
#(
  parameter int DIV_W = DEF_DIV_W,
  parameter int OVS   = DEF_OVS,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic               clock,
  input  logic               reset,
  uart_baud_timer_if.slave   bus
);

  localparam int              OVS_W    = $clog2(OVS);
  localparam logic [OVS_W-1:0] OVS_LAST = OVS_W'(OVS - 1);

  timer_state_t     state;
  timer_state_t     state_next;
  logic             launch;
  logic             running;
  logic [DIV_W-1:0] div_q;
  logic             mode_q;
  logic [CNT_W-1:0] bits_q;
  logic [OVS_W-1:0] ovs_cnt;
  logic [CNT_W-1:0] bit_cnt;
  logic             ovs_tick;
  logic             bit_tick;
  logic             done;

  // Ticks and done are qualified by enable so an abort never emits a pulse.
  assign running = (state == RUN) && bus.enable;

  always_comb begin
    state_next = state;
    launch     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.enable && ((bus.mode == MODE_PERIODIC) || bus.start)) begin
          launch     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (!bus.enable || done) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_q  <= '0;
      mode_q <= MODE_PERIODIC;
      bits_q <= '0;
    end else if (launch) begin
      div_q  <= (bus.divisor < DIV_W'(2)) ? DIV_W'(2) : bus.divisor;
      mode_q <= bus.mode;
      bits_q <= bus.bits;
    end
  end

  tick_prescaler #(
    .DIV_W (DIV_W)
  ) u_prescaler (
    .clock   (clock),
    .reset   (reset),
    .clear   (!running),
    .divisor (div_q),
    .tick    (ovs_tick)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ovs_cnt <= '0;
    end else if (!running) begin
      ovs_cnt <= '0;
    end else if (ovs_tick) begin
      ovs_cnt <= (ovs_cnt == OVS_LAST) ? '0 : ovs_cnt + OVS_W'(1);
    end
  end

  assign bit_tick = ovs_tick && (ovs_cnt == OVS_LAST);

  // One-shot completion ends the run, so the bit counter never exceeds bits_q.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bit_cnt <= '0;
    end else if (!running) begin
      bit_cnt <= '0;
    end else if (bit_tick && (mode_q == MODE_ONESHOT)) begin
      bit_cnt <= bit_cnt + CNT_W'(1);
    end
  end

  assign done = running && (mode_q == MODE_ONESHOT) &&
                ((bits_q == '0) || (bit_tick && (bit_cnt == bits_q - CNT_W'(1))));

  assign bus.ovs_tick = ovs_tick;
  assign bus.bit_tick = bit_tick;
  assign bus.busy     = (state == RUN);
  assign bus.done     = done;

`ifdef UART_BAUD_TIMER_HALF_EN
  localparam logic [OVS_W-1:0] HALF_PRE = OVS_W'(OVS / 2 - 1);
  assign bus.half_tick = ovs_tick && (ovs_cnt == HALF_PRE);
`else
  assign bus.half_tick = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_baud_timer.sv
`default_nettype none
// ============================================================================
// tb_uart_baud_timer : table-driven directed bench for uart_baud_timer
// Rev 1.0
// ============================================================================
module tb_uart_baud_timer;
  import uart_timer_pkg::*;

  localparam int DIV_W = 24;
  localparam int CNT_W = 8;
  localparam int OVS   = 16;
  localparam int WIN   = 200;
  localparam int NVEC  = 9;

  logic clock = 1'b0;
  logic reset = 1'b1;

  uart_baud_timer_if #(.DIV_W(DIV_W), .CNT_W(CNT_W)) bus ();

  uart_baud_timer #(
    .DIV_W (DIV_W),
    .OVS   (OVS),
    .CNT_W (CNT_W)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    int   div;
    logic mode;
    int   bits;
    logic perturb;
    int   ovs_n;
    int   ovs_first;
    int   period;
    int   bit_n;
    int   bit_first;
    int   done_at;
    int   busy_n;
    int   half_n;
    int   half_first;
  } vec_t;

  vec_t vecs [NVEC];
  int   pass_n  = 0;
  int   total_n = 0;

  task automatic check(input string name, input int act, input int exp);
    total_n++;
    if (act == exp) pass_n++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Entry edge is the posedge after enable/start are raised; cycle c is sampled
  // on the negedge that falls between edge c-1 and edge c.
  task automatic run_vec(input int idx, input vec_t v);
    int ovs_n = 0, ovs_first = 0, last_ovs = 0, per_err = 0;
    int bit_n = 0, bit_first = 0, done_n = 0, done_at = 0, busy_n = 0;
    int half_n = 0, half_first = 0, coinc_err = 0;
    int exp_half_n, exp_half_first;
    @(negedge clock);
    bus.divisor = DIV_W'(v.div);
    bus.mode    = v.mode;
    bus.bits    = CNT_W'(v.bits);
    bus.start   = v.mode;
    bus.enable  = 1'b1;
    for (int c = 1; c <= WIN; c++) begin
      @(negedge clock);
      if (bus.ovs_tick) begin
        if (ovs_n == 0) ovs_first = c;
        else if (c - last_ovs != v.period) per_err++;
        last_ovs = c;
        ovs_n++;
      end
      if (bus.bit_tick) begin
        if (bit_n == 0) bit_first = c;
        bit_n++;
      end
      if (bus.half_tick) begin
        if (half_n == 0) half_first = c;
        half_n++;
      end
      if (bus.busy) busy_n++;
      if (bus.done) begin
        done_n++;
        done_at = c;
        if (v.bits != 0 && !bus.bit_tick) coinc_err++;
      end
      bus.start = v.perturb && (c == 50);
      if (v.perturb && c == 50) begin
        bus.divisor = DIV_W'(10);
        bus.bits    = CNT_W'(1);
      end
    end
`ifdef UART_BAUD_TIMER_HALF_EN
    exp_half_n     = v.half_n;
    exp_half_first = v.half_first;
`else
    exp_half_n     = 0;
    exp_half_first = 0;
`endif
    check($sformatf("v%0d_ovs_count", idx), ovs_n, v.ovs_n);
    check($sformatf("v%0d_ovs_first", idx), ovs_first, v.ovs_first);
    check($sformatf("v%0d_ovs_period_err", idx), per_err, 0);
    check($sformatf("v%0d_bit_count", idx), bit_n, v.bit_n);
    check($sformatf("v%0d_bit_first", idx), bit_first, v.bit_first);
    check($sformatf("v%0d_done_cycle", idx), done_at, v.done_at);
    check($sformatf("v%0d_done_count", idx), done_n, (v.done_at != 0) ? 1 : 0);
    check($sformatf("v%0d_done_bit_coinc", idx), coinc_err, 0);
    check($sformatf("v%0d_busy_cycles", idx), busy_n, v.busy_n);
    check($sformatf("v%0d_half_count", idx), half_n, exp_half_n);
    check($sformatf("v%0d_half_first", idx), half_first, exp_half_first);
    bus.enable = 1'b0;
    bus.start  = 1'b0;
    @(negedge clock);
    check($sformatf("v%0d_busy_after_disable", idx), int'(bus.busy), 0);
    @(negedge clock);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int act;
    //          div mode bits pert ovs_n first per bit_n bfirst done busy half hfirst
    vecs[0] = '{4, 1'b0, 0, 1'b0, 50,  4, 4, 3, 64,   0, 200, 3, 32};
    vecs[1] = '{4, 1'b1, 3, 1'b0, 48,  4, 4, 3, 64, 192, 192, 3, 32};
    vecs[2] = '{4, 1'b1, 0, 1'b0,  0,  0, 4, 0,  0,   1,   1, 0,  0};
    vecs[3] = '{1, 1'b0, 0, 1'b0, 100, 2, 2, 6, 32,   0, 200, 6, 16};
    vecs[4] = '{0, 1'b0, 0, 1'b0, 100, 2, 2, 6, 32,   0, 200, 6, 16};
    vecs[5] = '{3, 1'b1, 1, 1'b0, 16,  3, 3, 1, 48,  48,  48, 1, 24};
    vecs[6] = '{2, 1'b1, 2, 1'b0, 32,  2, 2, 2, 32,  64,  64, 2, 16};
    vecs[7] = '{5, 1'b0, 0, 1'b0, 40,  5, 5, 2, 80,   0, 200, 3, 40};
    vecs[8] = '{4, 1'b1, 3, 1'b1, 48,  4, 4, 3, 64, 192, 192, 3, 32};

    bus.enable  = 1'b0;
    bus.divisor = '0;
    bus.mode    = MODE_PERIODIC;
    bus.start   = 1'b0;
    bus.bits    = '0;

    // Held reset must dominate an otherwise valid launch condition.
    repeat (3) @(negedge clock);
    bus.enable  = 1'b1;
    bus.divisor = DIV_W'(4);
    repeat (10) @(negedge clock);
    act = int'(bus.busy) + int'(bus.ovs_tick) + int'(bus.bit_tick) +
          int'(bus.half_tick) + int'(bus.done);
    check("reset_outputs_zero", act, 0);
    bus.enable = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("post_reset_idle_busy", int'(bus.busy), 0);

    for (int i = 0; i < NVEC; i++) run_vec(i, vecs[i]);

    // Enable dropped mid one-shot: abort without done, then no relaunch without start.
    @(negedge clock);
    bus.divisor = DIV_W'(4);
    bus.mode    = MODE_ONESHOT;
    bus.bits    = CNT_W'(3);
    bus.start   = 1'b1;
    bus.enable  = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    repeat (99) @(negedge clock);
    check("abort_busy_before", int'(bus.busy), 1);
    bus.enable = 1'b0;
    @(negedge clock);
    act = int'(bus.busy) + int'(bus.ovs_tick) + int'(bus.bit_tick) + int'(bus.done);
    check("abort_outputs_zero", act, 0);
    bus.enable = 1'b1;
    act = 0;
    for (int c = 0; c < 150; c++) begin
      @(negedge clock);
      act += int'(bus.busy) + int'(bus.ovs_tick) + int'(bus.bit_tick) + int'(bus.done);
    end
    check("abort_no_relaunch_activity", act, 0);
    bus.enable = 1'b0;
    @(negedge clock);

    // Asynchronous reset mid periodic run at cycle 100 (an ovs_tick cycle).
    bus.mode   = MODE_PERIODIC;
    bus.enable = 1'b1;
    repeat (100) @(negedge clock);
    check("rst_mid_ovs_before", int'(bus.ovs_tick), 1);
    check("rst_mid_busy_before", int'(bus.busy), 1);
    #1 reset = 1'b1;
    #1;
    act = int'(bus.busy) + int'(bus.ovs_tick) + int'(bus.bit_tick) + int'(bus.done);
    check("rst_mid_outputs_immediate", act, 0);
    bus.mode  = MODE_ONESHOT;
    bus.start = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    act = 0;
    for (int c = 0; c < 150; c++) begin
      @(negedge clock);
      act += int'(bus.busy) + int'(bus.ovs_tick) + int'(bus.bit_tick) + int'(bus.done);
    end
    check("rst_release_no_start_activity", act, 0);

    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

endmodule
`default_nettype wire
